// File: rtl/as6501_if.sv
// as6501_if: AS6501 serial result deserializer with gc time-stamping, gate classification and AXI-Stream output.
module as6501_if #(
  parameter int GC_W    = 48,
  parameter int FCR_LEN = 16
) (
  input  logic            lclk_i,
  input  logic            arstn,
  input  logic            enable,
  input  logic            reg_enable_tdc_i,
  input  logic            reg_enable200_i,
  input  logic            command_enable,
  input  logic [2:0]      command_i,
  input  logic            start_gc_i,
  input  logic            pps_i,
  input  logic            gc_rst,
  input  logic [15:0]     index_stop_bitwise_i,
  input  logic [31:0]     gate0_i,
  input  logic [31:0]     gate1_i,
  input  logic [15:0]     shift_tdc_time_i,
  input  logic [15:0]     shift_gc_back_i,
  input  logic            frame_i,
  input  logic            sdi_i,
  output logic [127:0]    m_axis_tdata,
  output logic            m_axis_tvalid,
  output logic [3:0]      m_axis_tuser,
  input  logic            m_axis_tready,
  output logic            fifo_calib_rst,
  output logic [1:0]      click_result,
  output logic            start_gc_o,
  output logic [GC_W-1:0] gc,
  output logic [15:0]     total_count_o
);
  localparam int FW = $clog2(FCR_LEN + 1);
  logic            busy_q, busy_d, wv_q, wv_d, ev_v_q, ev_v_d;
  logic [5:0]      cnt_q, cnt_d, n_c;
  logic [31:0]     sh_q, sh_d, msk_s, msk_i;
  logic [4:0]      iw_q, iw_d, sw_q, sw_d, iw_c, sw_c;
  logic [GC_W-1:0] gcc_q, gcc_d, gcs_q, gcs_d, gc_q, gc_d;
  logic [15:0]     idx_q, idx_d, tm_q, tm_d, tm_c, tot_q, tot_d;
  logic [1:0]      click_q, click_d;
  logic            tvalid_q, tvalid_d, pps_q, pps_d, start_q, start_d, load;
  logic [81:0]     tdata_q, tdata_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [FW-1:0]   fcr_q, fcr_d;
  always_comb begin
    iw_c    = (index_stop_bitwise_i[7:0] > 8'd16) ? 5'd16 : index_stop_bitwise_i[4:0];
    sw_c    = (index_stop_bitwise_i[15:8] > 8'd16) ? 5'd16 : index_stop_bitwise_i[12:8];
    n_c     = (iw_c == 5'd0 && sw_c == 5'd0) ? 6'd1 : {1'b0, iw_c} + {1'b0, sw_c};
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    iw_d    = iw_q;
    sw_d    = sw_q;
    wv_d    = 1'b0;
    if (!enable) begin
      busy_d = 1'b0;
    end else if (!busy_q && frame_i && reg_enable_tdc_i) begin
      sh_d   = {31'd0, sdi_i};
      iw_d   = iw_c;
      sw_d   = sw_c;
      cnt_d  = n_c - 6'd1;
      busy_d = n_c != 6'd1;
      wv_d   = n_c == 6'd1;
    end else if (busy_q) begin
      sh_d   = {sh_q[30:0], sdi_i};
      cnt_d  = cnt_q - 6'd1;
      busy_d = cnt_q != 6'd1;
      wv_d   = cnt_q == 6'd1;
    end
    gcc_d = wv_d ? gc_q : gcc_q;
  end
  // Second stage splits the finished word using the widths latched at its start.
  always_comb begin
    msk_s   = (32'd1 << sw_q) - 32'd1;
    msk_i   = (32'd1 << iw_q) - 32'd1;
    tm_c    = (sh_q[15:0] & msk_s[15:0]) + shift_tdc_time_i;
    ev_v_d  = wv_q;
    idx_d   = wv_q ? ((sh_q >> sw_q) & msk_i) : {16'd0, idx_q};
    tm_d    = wv_q ? tm_c : tm_q;
    gcs_d   = wv_q ? gcc_q - GC_W'(shift_gc_back_i) : gcs_q;
    click_d = wv_q ? {tm_c >= gate1_i[15:0] && tm_c <= gate1_i[31:16],
                      tm_c >= gate0_i[15:0] && tm_c <= gate0_i[31:16]} : click_q;
  end
  always_comb begin
    load     = ev_v_q && enable && (cmd_q == 3'd4 || (cmd_q == 3'd3 && click_q != 2'd0)) &&
               (!tvalid_q || m_axis_tready);
    tvalid_d = load || (tvalid_q && !m_axis_tready);
    tdata_d  = load ? {click_q, idx_q, tm_q, gcs_q} : tdata_q;
    tot_d    = tot_q + 16'(load);
    pps_d    = pps_i;
    start_d  = start_q || (start_gc_i && pps_i && !pps_q);
    gc_d     = gc_rst ? '0 : (start_q && reg_enable200_i) ? gc_q + 1'b1 : gc_q;
    cmd_d    = command_enable ? command_i : cmd_q;
    fcr_d    = (command_enable && command_i != cmd_q) ? FW'(FCR_LEN) :
               (fcr_q != '0) ? fcr_q - 1'b1 : fcr_q;
  end
  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      iw_q     <= '0;
      sw_q     <= '0;
      wv_q     <= 1'b0;
      gcc_q    <= '0;
      ev_v_q   <= 1'b0;
      idx_q    <= '0;
      tm_q     <= '0;
      gcs_q    <= '0;
      click_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tot_q    <= '0;
      pps_q    <= 1'b0;
      start_q  <= 1'b0;
      gc_q     <= '0;
      cmd_q    <= '0;
      fcr_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      iw_q     <= iw_d;
      sw_q     <= sw_d;
      wv_q     <= wv_d;
      gcc_q    <= gcc_d;
      ev_v_q   <= ev_v_d;
      idx_q    <= idx_d;
      tm_q     <= tm_d;
      gcs_q    <= gcs_d;
      click_q  <= click_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tot_q    <= tot_d;
      pps_q    <= pps_d;
      start_q  <= start_d;
      gc_q     <= gc_d;
      cmd_q    <= cmd_d;
      fcr_q    <= fcr_d;
    end
  end
  assign m_axis_tdata   = {46'd0, tdata_q};
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tuser   = {2'b00, tdata_q[81:80]};
  assign fifo_calib_rst = fcr_q != '0;
  assign click_result   = click_q;
  assign start_gc_o     = start_q;
  assign gc             = gc_q;
  assign total_count_o  = tot_q;
endmodule

// File: tb/tb_as6501_if.sv
// tb_as6501_if: directed and randomized checks of as6501_if against an arithmetic reference model.
module tb_as6501_if;
  logic         clk = 1'b0;
  logic         arstn, enable, reg_enable_tdc_i, reg_enable200_i, command_enable;
  logic [2:0]   command_i;
  logic         start_gc_i, pps_i, gc_rst, frame_i, sdi_i, m_axis_tready;
  logic [15:0]  index_stop_bitwise_i, shift_tdc_time_i, shift_gc_back_i;
  logic [31:0]  gate0_i, gate1_i;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid, fifo_calib_rst, start_gc_o;
  logic [3:0]   m_axis_tuser;
  logic [1:0]   click_result;
  logic [47:0]  gc;
  logic [15:0]  total_count_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  as6501_if dut (
    .lclk_i(clk), .arstn(arstn), .enable(enable), .reg_enable_tdc_i(reg_enable_tdc_i),
    .reg_enable200_i(reg_enable200_i), .command_enable(command_enable), .command_i(command_i),
    .start_gc_i(start_gc_i), .pps_i(pps_i), .gc_rst(gc_rst),
    .index_stop_bitwise_i(index_stop_bitwise_i), .gate0_i(gate0_i), .gate1_i(gate1_i),
    .shift_tdc_time_i(shift_tdc_time_i), .shift_gc_back_i(shift_gc_back_i),
    .frame_i(frame_i), .sdi_i(sdi_i), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready), .fifo_calib_rst(fifo_calib_rst),
    .click_result(click_result), .start_gc_o(start_gc_o), .gc(gc), .total_count_o(total_count_o)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Expected beat derived straight from the decoding and gating rules.
  function automatic logic [127:0] model(input longint unsigned w, input int iw, input int sw,
                                         input logic [47:0] g, input logic [15:0] sgb,
                                         input logic [15:0] stt, input logic [31:0] g0,
                                         input logic [31:0] g1);
    int ie = iw > 16 ? 16 : iw;
    int se = sw > 16 ? 16 : sw;
    longint unsigned idx = (w >> se) % (longint'(1) << ie);
    longint unsigned stp = w % (longint'(1) << se);
    longint unsigned t = (stp + longint'(stt)) % 65536;
    logic [47:0] gcs = g - {32'd0, sgb};
    logic c0 = t >= longint'(g0[15:0]) && t <= longint'(g0[31:16]);
    logic c1 = t >= longint'(g1[15:0]) && t <= longint'(g1[31:16]);
    logic [15:0] i16 = idx[15:0];
    logic [15:0] t16 = t[15:0];
    return {46'd0, c1, c0, i16, t16, gcs};
  endfunction
  task automatic send_word(input longint unsigned w, input int n, output logic [47:0] g);
    g = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_i = (i == 0);
      sdi_i = w[n-1-i];
      if (i == n - 1) g = gc;
    end
    @(negedge clk);
    frame_i = 1'b0;
    sdi_i = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (m_axis_tvalid) got = 1'b1;
      else @(negedge clk);
    end
    chk(tag, 128'(got), 128'(1'b1));
  endtask
  task automatic no_valid(input string tag);
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen += int'(m_axis_tvalid);
    end
    chk(tag, 128'(seen), 128'(0));
  endtask
  task automatic set_cmd(input logic [2:0] c);
    @(negedge clk);
    command_enable = 1'b1;
    command_i = c;
    @(negedge clk);
    command_enable = 1'b0;
  endtask
  initial begin
    logic [47:0] g;
    logic [127:0] e, first;
    logic [15:0] t0;
    logic stable;
    int cnt;
    arstn = 0; enable = 1; reg_enable_tdc_i = 1; reg_enable200_i = 0; command_enable = 0;
    command_i = 0; start_gc_i = 0; pps_i = 0; gc_rst = 0; frame_i = 0; sdi_i = 0;
    m_axis_tready = 1; index_stop_bitwise_i = 16'h0E04; shift_tdc_time_i = 0;
    shift_gc_back_i = 0; gate0_i = 32'hff000064; gate1_i = 32'hff000064;
    repeat (3) @(negedge clk);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_misc", 128'({m_axis_tvalid, m_axis_tuser, fifo_calib_rst, click_result, start_gc_o, gc, total_count_o}), '0);
    arstn = 1;
    @(negedge clk);
    command_enable = 1; command_i = 3'd4;
    @(negedge clk);
    command_enable = 0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cnt += int'(fifo_calib_rst);
      @(negedge clk);
    end
    chk("fcr_len", 128'(cnt), 128'(16));
    send_word(64'h2C0AB, 18, g);
    wait_valid("ev1_valid");
    chk("ev1_index", 128'(m_axis_tdata[79:64]), 128'(16'hB));
    chk("ev1_time", 128'(m_axis_tdata[63:48]), 128'(16'h00AB));
    chk("ev1_click", 128'(click_result), 128'(2'b11));
    chk("ev1_total", 128'(total_count_o), 128'(1));
    chk("ev1_model", m_axis_tdata, model(64'h2C0AB, 4, 14, g, 16'd0, 16'd0, gate0_i, gate1_i));
    set_cmd(3'd3);
    send_word((64'hB << 14) | 64'h50, 18, g);
    no_valid("m3_novalid");
    chk("m3_click", 128'(click_result), 128'(0));
    set_cmd(3'd4);
    send_word((64'hB << 14) | 64'h50, 18, g);
    wait_valid("m4_valid");
    chk("m4_tuser", 128'(m_axis_tuser), 128'(0));
    chk("m4_model", m_axis_tdata, model((64'hB << 14) | 64'h50, 4, 14, g, 16'd0, 16'd0, gate0_i, gate1_i));
    chk("m4_total", 128'(total_count_o), 128'(2));
    @(negedge clk);
    start_gc_i = 1; reg_enable200_i = 1; pps_i = 1;
    @(negedge clk);
    @(negedge clk);
    chk("gc_started", 128'(start_gc_o), 128'(1));
    g = gc;
    @(negedge clk);
    chk("gc_inc", 128'(gc), 128'(g + 48'd1));
    gc_rst = 1;
    @(negedge clk);
    gc_rst = 0;
    chk("gc_rst", 128'(gc), 128'(0));
    @(negedge clk);
    chk("gc_after_rst", 128'(gc), 128'(1));
    reg_enable200_i = 0; gc_rst = 1;
    @(negedge clk);
    gc_rst = 0; reg_enable200_i = 1;
    repeat (5) @(negedge clk);
    reg_enable200_i = 0;
    chk("gc_five", 128'(gc), 128'(5));
    shift_gc_back_i = 16'd10;
    send_word(64'h2C0AB, 18, g);
    wait_valid("wrap_valid");
    chk("wrap_gcs", 128'(m_axis_tdata[47:0]), 128'(48'hFFFF_FFFF_FFFB));
    shift_gc_back_i = 0;
    @(negedge clk);
    m_axis_tready = 0;
    t0 = total_count_o;
    send_word((64'h1 << 14) | 64'h100, 18, g);
    first = model((64'h1 << 14) | 64'h100, 4, 14, g, 16'd0, 16'd0, gate0_i, gate1_i);
    wait_valid("hold_valid");
    send_word((64'h2 << 14) | 64'h200, 18, g);
    send_word((64'h3 << 14) | 64'h300, 18, g);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!m_axis_tvalid || m_axis_tdata !== first) stable = 0;
    end
    chk("hold_stable", 128'(stable), 128'(1));
    chk("hold_data", m_axis_tdata, first);
    chk("hold_total", 128'(total_count_o), 128'(t0 + 16'd1));
    m_axis_tready = 1;
    @(negedge clk);
    chk("hold_drained", 128'(m_axis_tvalid), 128'(0));
    t0 = total_count_o;
    @(negedge clk);
    frame_i = 1; sdi_i = 1;
    @(negedge clk);
    frame_i = 0;
    repeat (3) @(negedge clk);
    enable = 0;
    @(negedge clk);
    enable = 1;
    no_valid("abort_novalid");
    chk("abort_total", 128'(total_count_o), 128'(t0));
    @(negedge clk);
    frame_i = 1; sdi_i = 1;
    @(negedge clk);
    frame_i = 0;
    repeat (4) @(negedge clk);
    #2 arstn = 0;
    #1;
    chk("arst_tdata", m_axis_tdata, '0);
    chk("arst_misc", 128'({m_axis_tvalid, m_axis_tuser, fifo_calib_rst, click_result, start_gc_o, gc, total_count_o}), '0);
    sdi_i = 0;
    @(negedge clk);
    arstn = 1;
    set_cmd(3'd4);
    send_word(64'h2C0AB, 18, g);
    wait_valid("post_rst_valid");
    chk("post_rst_model", m_axis_tdata, model(64'h2C0AB, 4, 14, g, 16'd0, 16'd0, gate0_i, gate1_i));
    chk("post_rst_total", 128'(total_count_o), 128'(1));
    pps_i = 0;
    @(negedge clk);
    pps_i = 1; reg_enable200_i = 1;
    for (int k = 0; k < 12; k++) begin
      int iw = $urandom_range(0, 20);
      int sw = $urandom_range(0, 20);
      int n = (iw > 16 ? 16 : iw) + (sw > 16 ? 16 : sw);
      longint unsigned w;
      logic [15:0] lo0 = 16'($urandom_range(0, 40000));
      logic [15:0] lo1 = 16'($urandom_range(0, 40000));
      if (n == 0) n = 1;
      w = (longint'($urandom) << 32 | longint'($urandom)) % (longint'(1) << n);
      index_stop_bitwise_i = {8'(sw), 8'(iw)};
      gate0_i = {lo0 + 16'($urandom_range(0, 25000)), lo0};
      gate1_i = {lo1 + 16'($urandom_range(0, 25000)), lo1};
      shift_tdc_time_i = 16'($urandom);
      shift_gc_back_i = 16'($urandom);
      t0 = total_count_o;
      send_word(w, n, g);
      e = model(w, iw, sw, g, shift_gc_back_i, shift_tdc_time_i, gate0_i, gate1_i);
      wait_valid("rnd_valid");
      chk("rnd_tdata", m_axis_tdata, e);
      chk("rnd_tuser", 128'(m_axis_tuser), 128'({2'b00, e[81:80]}));
      chk("rnd_total", 128'(total_count_o), 128'(t0 + 16'd1));
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
